// File: rtl/hex_scan_if.sv
// Host-side and display-side signals of the seven-segment scan controller.
// Latency: n/a (wires only).
// Backpressure: none; writes are always accepted.
// Signals:
//   wr_en/wr_addr/wr_data : byte-wide digit-pair write into the shadow buffer
//   blank_mask/blink_mask : live per-digit display controls
//   an_n/seg              : registered, active-low digit enables and segments
//   digit_idx             : current scan digit
//   frame_tick            : pulse on the first output cycle of digit 0 after a commit
//   upd_pending           : shadow holds writes not yet committed
interface hex_scan_if #(
    parameter int NUM_DIGITS = 8
);
    localparam int AW = $clog2(NUM_DIGITS / 2);
    localparam int DW = $clog2(NUM_DIGITS);

    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [7:0]            wr_data;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic [NUM_DIGITS-1:0] blink_mask;
    logic [NUM_DIGITS-1:0] an_n;
    logic [6:0]            seg;
    logic [DW-1:0]         digit_idx;
    logic                  frame_tick;
    logic                  upd_pending;

    // Host / display-consumer side.
    modport master (
        output wr_en, wr_addr, wr_data, blank_mask, blink_mask,
        input  an_n, seg, digit_idx, frame_tick, upd_pending
    );

    // Controller side.
    modport slave (
        input  wr_en, wr_addr, wr_data, blank_mask, blink_mask,
        output an_n, seg, digit_idx, frame_tick, upd_pending
    );
endinterface

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed 7-segment scanner with shadow/active buffers committed at frame wrap.
// Latency: an_n/seg reflect slot state one cycle later; writes show after the next commit.
// Backpressure: none; writes accepted every cycle, masks sampled live.
// Ports: clk, rst_n (async active-low), bus (hex_scan_if.slave: write port,
//        blank/blink masks, an_n, seg, digit_idx, frame_tick, upd_pending).
module hex_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int DEAD         = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    hex_scan_if.slave   bus
);
    localparam int AW = $clog2(NUM_DIGITS / 2);
    localparam int DW = $clog2(NUM_DIGITS);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] DIV_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [CW:0]   DEAD_LIM   = (CW + 1)'(DEAD);
    localparam logic [NUM_DIGITS-1:0] ONE = {{(NUM_DIGITS - 1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------
    logic [CW-1:0] div_cnt;
    logic [DW-1:0] digit_idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;   // 1 = blinking digits visible

    logic [3:0]    shadow [NUM_DIGITS];
    logic [3:0]    active [NUM_DIGITS];
    logic          upd_pending;

    logic [NUM_DIGITS-1:0] an_q;
    logic [6:0]            seg_q;
    logic                  tick_arm;
    logic                  frame_tick_q;

    logic slot_end;
    logic wrap;

    assign slot_end = (div_cnt == DIV_LAST);
    assign wrap     = slot_end && (digit_idx == DIGIT_LAST);

    // Digit-pair addressing: pair k covers digits 2k (low nibble) and 2k+1.
    logic [DW-1:0] wr_lo_idx;
    logic [DW-1:0] wr_hi_idx;

    assign wr_lo_idx = {bus.wr_addr, 1'b0};
    assign wr_hi_idx = {bus.wr_addr, 1'b1};

    // ------------------------------------------------------------------
    // Shared decoder: one nibble mux feeding one hex-to-segment table.
    // ------------------------------------------------------------------
    logic [3:0] cur_nib;
    logic [6:0] dec_seg;

    assign cur_nib = active[digit_idx];

    always_comb begin
        dec_seg = 7'h7F;
        case (cur_nib)
            4'h0: dec_seg = 7'h40;
            4'h1: dec_seg = 7'h79;
            4'h2: dec_seg = 7'h24;
            4'h3: dec_seg = 7'h30;
            4'h4: dec_seg = 7'h19;
            4'h5: dec_seg = 7'h12;
            4'h6: dec_seg = 7'h02;
            4'h7: dec_seg = 7'h78;
            4'h8: dec_seg = 7'h00;
            4'h9: dec_seg = 7'h10;
            4'hA: dec_seg = 7'h08;
            4'hB: dec_seg = 7'h03;
            4'hC: dec_seg = 7'h46;
            4'hD: dec_seg = 7'h21;
            4'hE: dec_seg = 7'h06;
            4'hF: dec_seg = 7'h0E;
            default: dec_seg = 7'h7F;
        endcase
    end

    // Next-cycle output values computed from the current slot state.
    logic                  in_dead;
    logic                  dark;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic [6:0]            seg_nxt;

    assign in_dead = ({1'b0, div_cnt} < DEAD_LIM);
    assign dark    = bus.blank_mask[digit_idx] ||
                     (bus.blink_mask[digit_idx] && !blink_phase);
    assign an_nxt  = in_dead ? {NUM_DIGITS{1'b1}} : ~(ONE << digit_idx);
    assign seg_nxt = dark ? 7'h7F : dec_seg;

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            digit_idx   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            if (slot_end) begin
                div_cnt <= '0;
                if (digit_idx == DIGIT_LAST) begin
                    digit_idx <= '0;
                end else begin
                    digit_idx <= digit_idx + DW'(1);
                end
            end else begin
                div_cnt <= div_cnt + CW'(1);
            end

            if (wrap) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Buffers. A write in the commit cycle lands in shadow only: active
    // takes the pre-write shadow, and upd_pending stays set for next frame.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= 4'h0;
                active[i] <= 4'h0;
            end
            upd_pending <= 1'b0;
        end else begin
            if (wrap) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    active[i] <= shadow[i];
                end
            end

            if (bus.wr_en) begin
                shadow[wr_lo_idx] <= bus.wr_data[3:0];
                shadow[wr_hi_idx] <= bus.wr_data[7:4];
            end

            if (bus.wr_en) begin
                upd_pending <= 1'b1;
            end else if (wrap) begin
                upd_pending <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers. frame_tick is delayed twice after the commit so it
    // lines up with the first registered output of digit 0; the post-reset
    // frame has no preceding commit and therefore no tick.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q         <= {NUM_DIGITS{1'b1}};
            seg_q        <= 7'h7F;
            tick_arm     <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            an_q         <= an_nxt;
            seg_q        <= seg_nxt;
            tick_arm     <= wrap;
            frame_tick_q <= tick_arm;
        end
    end

    assign bus.an_n        = an_q;
    assign bus.seg         = seg_q;
    assign bus.digit_idx   = digit_idx;
    assign bus.frame_tick  = frame_tick_q;
    assign bus.upd_pending = upd_pending;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed bench for hex_scan_ctrl with a 4-digit, 8-cycle-slot configuration.
// Cycle n = values seen 1 time unit after the n-th rising edge following reset release.
// Frame = 32 cycles; the output at cycle n reflects slot state count n-1.
module tb_hex_scan_ctrl;
    localparam int ND = 4;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    hex_scan_if #(.NUM_DIGITS(ND)) bus ();

    hex_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (8),
        .DEAD        (2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         c;
        logic [3:0] an;
        logic [6:0] sg;
        logic       ft;
        logic [1:0] di;
    } vec_t;

    vec_t tbl [13];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        if (n < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL goto: at cycle %0d, required target cycle %0d", cyc, n);
        end
        while (cyc < n) step();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [3:0] an, input logic [6:0] sg);
        chk({name, ".an_n"}, 32'(bus.an_n), 32'(an));
        chk({name, ".seg"},  32'(bus.seg),  32'(sg));
    endtask

    task automatic write(input logic addr, input logic [7:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic release_reset();
        #3 rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        rst_n = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.blank_mask = '0;
        bus.blink_mask = '0;

        //            cycle an     seg    ft    di
        tbl[0]  = '{1,  4'hF, 7'h40, 1'b0, 2'd0};
        tbl[1]  = '{2,  4'hF, 7'h40, 1'b0, 2'd0};
        tbl[2]  = '{3,  4'hE, 7'h40, 1'b0, 2'd0};
        tbl[3]  = '{8,  4'hE, 7'h40, 1'b0, 2'd1};
        tbl[4]  = '{9,  4'hF, 7'h40, 1'b0, 2'd1};
        tbl[5]  = '{10, 4'hF, 7'h40, 1'b0, 2'd1};
        tbl[6]  = '{11, 4'hD, 7'h40, 1'b0, 2'd1};
        tbl[7]  = '{17, 4'hF, 7'h40, 1'b0, 2'd2};
        tbl[8]  = '{19, 4'hB, 7'h40, 1'b0, 2'd2};
        tbl[9]  = '{27, 4'h7, 7'h40, 1'b0, 2'd3};
        tbl[10] = '{32, 4'h7, 7'h40, 1'b0, 2'd0};
        tbl[11] = '{33, 4'hF, 7'h40, 1'b1, 2'd0};
        tbl[12] = '{34, 4'hF, 7'h40, 1'b0, 2'd0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.an_n",        32'(bus.an_n), 32'hF);
        chk("rst.seg",         32'(bus.seg), 32'h7F);
        chk("rst.frame_tick",  32'(bus.frame_tick), 32'h0);
        chk("rst.upd_pending", 32'(bus.upd_pending), 32'h0);
        chk("rst.digit_idx",   32'(bus.digit_idx), 32'h0);
        release_reset();

        // First frame scan, table driven
        for (int i = 0; i < 13; i++) begin
            goto(tbl[i].c);
            chk($sformatf("scan%0d.an_n", tbl[i].c), 32'(bus.an_n), 32'(tbl[i].an));
            chk($sformatf("scan%0d.seg", tbl[i].c), 32'(bus.seg), 32'(tbl[i].sg));
            chk($sformatf("scan%0d.frame_tick", tbl[i].c), 32'(bus.frame_tick), 32'(tbl[i].ft));
            chk($sformatf("scan%0d.digit_idx", tbl[i].c), 32'(bus.digit_idx), 32'(tbl[i].di));
        end

        // Mid-frame write in frame 1, committed at end of frame 1
        goto(44);
        write(1'b1, 8'hA5);
        chk("wr.upd_pending", 32'(bus.upd_pending), 32'h1);
        goto(53); chk_out("wr.f1d2", 4'hB, 7'h40);
        goto(61); chk_out("wr.f1d3", 4'h7, 7'h40);
        chk("wr.pend_f1", 32'(bus.upd_pending), 32'h1);
        goto(69); chk_out("wr.f2d0", 4'hE, 7'h40);
        goto(85); chk_out("wr.f2d2", 4'hB, 7'h12);
        goto(93); chk_out("wr.f2d3", 4'h7, 7'h08);
        chk("wr.pend_f2", 32'(bus.upd_pending), 32'h0);

        // Write landing in the commit cycle (state count 95)
        goto(95);
        write(1'b0, 8'h3C);
        chk("cw.upd_pending", 32'(bus.upd_pending), 32'h1);
        goto(97);  chk("cw.frame_tick", 32'(bus.frame_tick), 32'h1);
        goto(101); chk_out("cw.f3d0", 4'hE, 7'h40);
        goto(109); chk_out("cw.f3d1", 4'hD, 7'h40);
        chk("cw.pend_f3", 32'(bus.upd_pending), 32'h1);
        goto(133); chk_out("cw.f4d0", 4'hE, 7'h46);
        goto(141); chk_out("cw.f4d1", 4'hD, 7'h30);
        chk("cw.pend_f4", 32'(bus.upd_pending), 32'h0);
        goto(149); chk_out("cw.f4d2", 4'hB, 7'h12);

        // Blank digit 1 in frame 5, then clear it mid-slot
        goto(160);
        bus.blank_mask = 4'b0010;
        goto(165); chk_out("blank.d0", 4'hE, 7'h46);
        goto(173); chk_out("blank.d1", 4'hD, 7'h7F);
        goto(175);
        bus.blank_mask = 4'b0000;
        step();
        chk_out("unblank.d1", 4'hD, 7'h30);

        // Blink digit 0: frames 6-7 hidden, frame 8 visible
        bus.blink_mask = 4'b0001;
        goto(197); chk_out("blink.f6d0", 4'hE, 7'h7F);
        goto(205); chk_out("blink.f6d1", 4'hD, 7'h30);
        goto(225); chk_out("blink.f7first", 4'hF, 7'h7F);
        chk("blink.f7tick", 32'(bus.frame_tick), 32'h1);
        goto(229); chk_out("blink.f7d0", 4'hE, 7'h7F);
        goto(257); chk_out("blink.f8first", 4'hF, 7'h46);
        goto(261); chk_out("blink.f8d0", 4'hE, 7'h46);
        bus.blink_mask = 4'b0000;

        // Reset in frame 9 at digit 2 with a pending write
        goto(290);
        write(1'b1, 8'hFF);
        goto(307);
        chk("mr.digit_idx_pre", 32'(bus.digit_idx), 32'h2);
        chk("mr.pend_pre", 32'(bus.upd_pending), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_out("mr.async", 4'hF, 7'h7F);
        chk("mr.pend", 32'(bus.upd_pending), 32'h0);
        chk("mr.digit_idx", 32'(bus.digit_idx), 32'h0);
        step();
        step();
        release_reset();
        goto(1);
        chk("mr.c1.frame_tick", 32'(bus.frame_tick), 32'h0);
        chk_out("mr.c1", 4'hF, 7'h40);
        goto(5);  chk_out("mr.d0", 4'hE, 7'h40);
        goto(13); chk_out("mr.d1", 4'hD, 7'h40);
        goto(21); chk_out("mr.d2", 4'hB, 7'h40);
        goto(29); chk_out("mr.d3", 4'h7, 7'h40);
        goto(33); chk("mr.frame_tick", 32'(bus.frame_tick), 32'h1);
        goto(53); chk_out("mr.f1d2", 4'hB, 7'h40);
        chk("mr.pend_f1", 32'(bus.upd_pending), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
